// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle control sequencer: states, instruction classes, datapath select codes.
// Pure declarations; no timing and no flow control.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_R, CLS_I, CLS_LOAD, CLS_STORE,
    CLS_BRANCH, CLS_JAL, CLS_LUI, CLS_AUIPC, CLS_ILL
  } cls_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_NOP    = 7'b0000000;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JAL    = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_SUB   = 2'b11;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_IMEM    = 2'b10;
  localparam logic [1:0] TRAP_DMEM    = 2'b11;

  function automatic cls_e classify(input logic [6:0] opc);
    cls_e cls;
    unique case (opc)
      OPC_R:      cls = CLS_R;
      OPC_I:      cls = CLS_I;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_JAL:    cls = CLS_JAL;
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_NOP:    cls = CLS_NOP;
      default:    cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_mem_watchdog.sv
// Counts consecutive request cycles without ack; timeout pulses combinationally in request cycle MEM_TIMEOUT
// when that cycle also lacks an ack. MEM_TIMEOUT = 0 disables it. Never stalls the requester.
module mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      assign timeout = 1'b0;
    end else begin : g_on
      localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
      localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

      logic [CNT_W-1:0] cnt_q, cnt_d;

      // cnt_q holds the number of earlier no-ack cycles in the current request.
      always_comb begin
        cnt_d = '0;
        if (req && !ack) cnt_d = cnt_q + CNT_W'(1);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign timeout = req && !ack && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, 3-5 cycles per instruction plus memory waits;
// stalls on imem/dmem req/ack, traps on watchdog timeout. MULTICYCLE_CTRL_PERF_CNT_EN adds cycle/instret counters.
module multicycle_ctrl_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_load,
  output logic        mdr_load,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        busy,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state_dbg
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d;
  logic [1:0] trap_cause_q, trap_cause_d;

  cls_e       dec_cls;
  state_e     retire_st;
  logic       br_taken;
  logic       cls_alu_src;
  logic [1:0] cls_alu_op;
  logic       wd_req, wd_ack, wd_timeout;

  assign dec_cls   = classify(opcode);
  assign retire_st = run ? ST_FETCH : ST_IDLE;
  assign br_taken  = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);

  assign cls_alu_src = !((cls_q == CLS_R) || (cls_q == CLS_BRANCH));
  assign cls_alu_op  = ((cls_q == CLS_R) || (cls_q == CLS_I)) ? ALU_FUNCT :
                       (cls_q == CLS_BRANCH)                    ? ALU_SUB   : ALU_ADD;

  // Derived from state rather than the request outputs to keep the timeout path loop-free.
  assign wd_req = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
  assign wd_ack = ((state_q == ST_FETCH) && imem_ack) || ((state_q == ST_MEMORY) && dmem_ack);

  mem_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_watchdog (
    .clk     (clk),
    .rst     (rst),
    .req     (wd_req),
    .ack     (wd_ack),
    .timeout (wd_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cls_q        <= CLS_NOP;
      trap_cause_q <= TRAP_NONE;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    trap_cause_d = trap_cause_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    ir_load      = 1'b0;
    mdr_load     = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SRC_PLUS4;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    alu_src      = 1'b0;
    alu_op       = ALU_ADD;

    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (wd_timeout) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_IMEM;
        end
      end

      ST_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == CLS_ILL) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        alu_src = cls_alu_src;
        alu_op  = cls_alu_op;
        unique case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_src  = br_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
            state_d = retire_st;
          end
          CLS_NOP: begin
            pc_we   = 1'b1;
            state_d = retire_st;
          end
          default: state_d = ST_WRITEBACK;
        endcase
      end

      ST_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        alu_src  = cls_alu_src;
        alu_op   = cls_alu_op;
        if (dmem_ack) begin
          if (cls_q == CLS_STORE) begin
            pc_we   = 1'b1;
            state_d = retire_st;
          end else begin
            mdr_load = 1'b1;
            state_d  = ST_WRITEBACK;
          end
        end else if (wd_timeout) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_DMEM;
        end
      end

      ST_WRITEBACK: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = retire_st;
        unique case (cls_q)
          CLS_LOAD: wb_sel = WB_MDR;
          CLS_JAL: begin
            wb_sel = WB_PC4;
            pc_src = PC_SRC_JAL;
          end
          CLS_LUI: wb_sel = WB_IMM;
          default: wb_sel = WB_ALU;
        endcase
      end

      ST_TRAP: begin
        state_d = ST_TRAP;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE) && (state_q != ST_TRAP);
  assign trap_cause = trap_cause_q;
  assign state_dbg  = state_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;

  // Every pc_we is a retire, so it doubles as the instret strobe.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + 32'(busy);
    instret_cnt_d = instret_cnt_q + 32'(pc_we);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench: a scoreboard queue holds expected output snapshots for retire, load-data and trap events,
// and a monitor compares each event as the DUT presents it.
module tb_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  logic rst, run, zero, imem_ack, dmem_ack;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic imem_req, dmem_req, dmem_we, ir_load, mdr_load, pc_we, reg_we, alu_src, busy;
  logic [1:0] pc_src, wb_sel, alu_op, trap_cause;
  logic [2:0] state_dbg;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3), .zero(zero),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .ir_load(ir_load), .mdr_load(mdr_load), .pc_we(pc_we),
    .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op),
    .busy(busy), .trap_cause(trap_cause), .state_dbg(state_dbg)
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic       ireq;
    logic       dreq;
    logic       dwe;
    logic       mdr;
    logic       pcwe;
    logic [1:0] pcsrc;
    logic       rwe;
    logic [1:0] wbs;
    logic       asrc;
    logic [1:0] aop;
    logic       bsy;
    logic [1:0] cause;
    logic [7:0] lat;
  } snap_t;

  snap_t expq[$];
  string nameq[$];
  int    st_log[$];
  int    total = 0;
  int    bad = 0;
  int    imem_wait = 0;
  int    dmem_wait = 0;
  int    ireq_cyc = 0;
  int    dreq_cyc = 0;
  int    mon_lat = 0;
  logic [2:0] mon_prev = 3'd0;
  snap_t act, exp_s;
  string exp_nm;

  logic [31:0] all_outs;
  assign all_outs = {12'd0, imem_req, dmem_req, dmem_we, ir_load, mdr_load, pc_we, pc_src,
                     reg_we, wb_sel, alu_src, alu_op, busy, trap_cause, state_dbg};

  function automatic snap_t ret_wb(input logic [1:0] wbs, input logic [1:0] pcsrc, input int lat);
    snap_t s = '0;
    s.st = 3'd5; s.pcwe = 1'b1; s.rwe = 1'b1; s.wbs = wbs; s.pcsrc = pcsrc; s.bsy = 1'b1; s.lat = 8'(lat);
    return s;
  endfunction

  function automatic snap_t ret_ex(input logic asrc, input logic [1:0] aop, input logic [1:0] pcsrc, input int lat);
    snap_t s = '0;
    s.st = 3'd3; s.pcwe = 1'b1; s.pcsrc = pcsrc; s.asrc = asrc; s.aop = aop; s.bsy = 1'b1; s.lat = 8'(lat);
    return s;
  endfunction

  function automatic snap_t mem_ev(input logic store, input int lat);
    snap_t s = '0;
    s.st = 3'd4; s.dreq = 1'b1; s.dwe = store; s.pcwe = store; s.mdr = !store;
    s.asrc = 1'b1; s.aop = 2'b00; s.bsy = 1'b1; s.lat = 8'(lat);
    return s;
  endfunction

  function automatic snap_t trap_ev(input logic [1:0] cause, input int lat);
    snap_t s = '0;
    s.st = 3'd6; s.cause = cause; s.lat = 8'(lat);
    return s;
  endfunction

  task automatic push(input string nm, input snap_t s);
    expq.push_back(s);
    nameq.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Memory models: ack after a programmable number of wait cycles, never without a request.
  initial begin
    int icnt, dcnt;
    icnt = 0; dcnt = 0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (imem_req) begin imem_ack = (icnt >= imem_wait); icnt++; end
      else begin imem_ack = 1'b0; icnt = 0; end
      if (dmem_req) begin dmem_ack = (dcnt >= dmem_wait); dcnt++; end
      else begin dmem_ack = 1'b0; dcnt = 0; end
    end
  end

  // Monitor: latency counts FETCH entry as cycle 1.
  initial begin
    forever begin
      @(negedge clk);
      if (state_dbg == 3'd1 && mon_prev != 3'd1) mon_lat = 1;
      else if (mon_lat < 255) mon_lat++;
      if (imem_req) ireq_cyc++;
      if (dmem_req) dreq_cyc++;
      if (pc_we || mdr_load || (state_dbg == 3'd6 && mon_prev != 3'd6)) begin
        act.st = state_dbg; act.ireq = imem_req; act.dreq = dmem_req; act.dwe = dmem_we;
        act.mdr = mdr_load; act.pcwe = pc_we; act.pcsrc = pc_src; act.rwe = reg_we;
        act.wbs = wb_sel; act.asrc = alu_src; act.aop = alu_op; act.bsy = busy;
        act.cause = trap_cause; act.lat = 8'(mon_lat);
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event got=%h exp=none", act);
        end else begin
          exp_s  = expq.pop_front();
          exp_nm = nameq.pop_front();
          if (act.st == 3'd5) begin
            act.asrc = 1'b0; act.aop = 2'b00; exp_s.asrc = 1'b0; exp_s.aop = 2'b00;
          end
          if (act !== exp_s) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", exp_nm, act, exp_s);
          end
        end
      end
      mon_prev = state_dbg;
    end
  end

  task automatic run_one(input string nm, input logic [6:0] opc, input logic [2:0] f3, input logic z,
                         input int iw, input int dw, input int drop_st, input int fin_st);
    int n;
    rst = 1'b1; run = 1'b0;
    imem_wait = iw; dmem_wait = dw; opcode = opc; funct3 = f3; zero = z;
    #1 chk({nm, ":reset_outs"}, all_outs, 32'd0);
    repeat (2) @(negedge clk);
    ireq_cyc = 0; dreq_cyc = 0;
    st_log.delete();
    rst = 1'b0; run = 1'b1;
    n = 0;
    do begin @(negedge clk); #2; n++; end while (state_dbg == 3'd0 && n < 10);
    chk({nm, ":fetch_entry"}, state_dbg, 32'd1);
    st_log.push_back(int'(state_dbg));
    if (drop_st == 1) run = 1'b0;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk); #2; n++;
      st_log.push_back(int'(state_dbg));
      if (drop_st >= 0 && int'(state_dbg) == drop_st) run = 1'b0;
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL %s:event_timeout pending=%0d", nm, expq.size());
      expq.delete(); nameq.delete();
    end
    @(negedge clk); #2;
    st_log.push_back(int'(state_dbg));
    chk({nm, ":next_state"}, state_dbg, 32'(fin_st));
  endtask

  initial begin
    int seq_exp[5];
    rst = 1'b1; run = 1'b0; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0;
    seq_exp = '{1, 2, 3, 5, 1};

    push("r_add", ret_wb(2'b00, 2'b00, 4));
    run_one("r_add", 7'b0110011, 3'b000, 1'b0, 0, 0, -1, 1);
    chk("r_add:seq_len", st_log.size(), 32'd5);
    for (int k = 0; k < 5; k++) chk("r_add:seq", st_log[k], 32'(seq_exp[k]));

    push("load_mdr", mem_ev(1'b0, 7));
    push("load_wb", ret_wb(2'b01, 2'b00, 8));
    run_one("load_w3", 7'b0000011, 3'b010, 1'b0, 0, 3, 1, 0);
    chk("load_w3:dmem_req_cycles", dreq_cyc, 32'd4);

    push("beq_z1", ret_ex(1'b0, 2'b11, 2'b01, 3));
    run_one("beq_z1", 7'b1100011, 3'b000, 1'b1, 0, 0, 1, 0);
    push("bne_z1", ret_ex(1'b0, 2'b11, 2'b00, 3));
    run_one("bne_z1", 7'b1100011, 3'b001, 1'b1, 0, 0, 1, 0);
    push("bne_z0", ret_ex(1'b0, 2'b11, 2'b01, 3));
    run_one("bne_z0", 7'b1100011, 3'b001, 1'b0, 0, 0, 1, 0);
    push("blt_z0", ret_ex(1'b0, 2'b11, 2'b00, 3));
    run_one("blt_z0", 7'b1100011, 3'b100, 1'b0, 0, 0, 1, 0);

    push("addi", ret_wb(2'b00, 2'b00, 4));
    run_one("addi", 7'b0010011, 3'b000, 1'b0, 0, 0, 1, 0);
    push("jal", ret_wb(2'b10, 2'b10, 4));
    run_one("jal", 7'b1101111, 3'b000, 1'b0, 0, 0, 1, 0);
    push("lui", ret_wb(2'b11, 2'b00, 4));
    run_one("lui", 7'b0110111, 3'b000, 1'b0, 0, 0, 1, 0);
    push("auipc", ret_wb(2'b00, 2'b00, 4));
    run_one("auipc", 7'b0010111, 3'b000, 1'b0, 0, 0, 1, 0);
    push("nop", ret_ex(1'b1, 2'b00, 2'b00, 3));
    run_one("nop", 7'b0000000, 3'b000, 1'b0, 0, 0, 1, 0);
    push("store", mem_ev(1'b1, 4));
    run_one("store", 7'b0100011, 3'b010, 1'b0, 0, 0, 1, 0);

    push("illegal", trap_ev(2'b01, 3));
    run_one("illegal", 7'b1111111, 3'b000, 1'b0, 0, 0, -1, 6);
    repeat (5) @(negedge clk);
    chk("illegal:stay_trap", state_dbg, 32'd6);
    chk("illegal:cause_sticky", trap_cause, 32'd1);
    chk("illegal:busy", busy, 32'd0);

    push("imem_to", trap_ev(2'b10, 16));
    run_one("imem_to", 7'b0110011, 3'b000, 1'b0, 1000, 0, 1, 6);
    chk("imem_to:req_cycles", ireq_cyc, 32'd15);

    push("imem_ack15", ret_wb(2'b00, 2'b00, 18));
    run_one("imem_ack15", 7'b0110011, 3'b000, 1'b0, 14, 0, 1, 0);
    chk("imem_ack15:req_cycles", ireq_cyc, 32'd15);

    push("dmem_to", trap_ev(2'b11, 19));
    run_one("dmem_to", 7'b0000011, 3'b010, 1'b0, 0, 1000, 1, 6);
    chk("dmem_to:req_cycles", dreq_cyc, 32'd15);

    push("store_rundrop", mem_ev(1'b1, 6));
    run_one("store_rundrop", 7'b0100011, 3'b010, 1'b0, 0, 2, 4, 0);

    run_one("rst_fetch", 7'b0110011, 3'b000, 1'b0, 1000, 0, -1, 1);
    rst = 1'b1;
    #1 chk("rst_fetch:outs_zero", all_outs, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_fetch:no_pending", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
